// File: rtl/multdiv_pkg.sv
// Shared constants for the multiply/divide sequencer: state encoding,
// HI/LO source select values and default unit latencies.
package multdiv_pkg;

    localparam int DEFAULT_MULT_LAT = 32;
    localparam int DEFAULT_DIV_LAT  = 32;
    localparam int DEFAULT_CNT_W    = 6;

    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_DIV  = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_START = 3'd2;
    localparam state_t S_RUN   = 3'd3;
    localparam state_t S_WB    = 3'd4;
    localparam state_t S_ERR   = 3'd5;

endpackage

// File: rtl/latency_counter.sv
// Loadable down-counter with a zero flag; counts out the fixed latency
// of the multiply or divide unit.
module latency_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A load wins over a decrement; the counter saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences MULT/MULTU/DIV/DIVU on the shared mult/div units: loads the aux
// operand registers, pulses the unit start, waits its latency, writes HI/LO.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int MULT_LAT = DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = DEFAULT_DIV_LAT,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic req_mult,
    input  logic req_div,
    input  logic hilo_read,
    input  logic div_by_zero,
    output logic aux_a_en,
    output logic aux_b_en,
    output logic mult_op,
    output logic div_op,
    output logic multdiv_sel,
    output logic hilo_we,
    output logic busy,
    output logic stall,
    output logic done,
    output logic div_zero_exc
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    state_t           state_q;
    state_t           state_d;
    logic             op_is_div_q;
    logic             op_is_div_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    // RUN lasts exactly LAT cycles because the counter starts at LAT-1.
    assign cnt_load_val = op_is_div_q ? DIV_LOAD : MULT_LOAD;

    latency_counter #(
        .CNT_W (CNT_W)
    ) u_latency_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Multiply wins when both requests arrive together; a zero divisor
    // aborts a divide ahead of the latency count finishing.
    always_comb begin
        state_d     = state_q;
        op_is_div_d = op_is_div_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_mult || req_div) begin
                    state_d     = S_LOAD;
                    op_is_div_d = req_div && !req_mult;
                end
            end
            S_LOAD: begin
                state_d = S_START;
            end
            S_START: begin
                cnt_load = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (op_is_div_q && div_by_zero) begin
                    state_d = S_ERR;
                end else if (cnt_zero) begin
                    state_d = S_WB;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_is_div_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_is_div_q <= op_is_div_d;
        end
    end

    // Everything except stall decodes the state register only.
    assign busy         = (state_q != S_IDLE);
    assign aux_a_en     = (state_q == S_LOAD);
    assign aux_b_en     = (state_q == S_LOAD);
    assign mult_op      = (state_q == S_START) && !op_is_div_q;
    assign div_op       = (state_q == S_START) && op_is_div_q;
    assign hilo_we      = (state_q == S_WB);
    assign done         = (state_q == S_WB);
    assign div_zero_exc = (state_q == S_ERR);
    assign multdiv_sel  = (busy && op_is_div_q) ? SEL_DIV : SEL_MULT;

    // WB cycle is excluded from busy-stall on reads: the write lands at its
    // end, so the control unit simply reads one cycle later.
    assign stall = busy && (state_q != S_WB || req_mult || req_div)
                        && (hilo_read || req_mult || req_div);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer with 4-cycle unit latencies:
// stimulus queues expected pulses, a monitor pops them as the DUT fires.
module tb_multdiv_sequencer;

    localparam int LAT = 4;

    localparam logic [6:0] P_AUX = 7'b1100000;
    localparam logic [6:0] P_MUL = 7'b0010000;
    localparam logic [6:0] P_DIV = 7'b0001000;
    localparam logic [6:0] P_WB  = 7'b0000110;
    localparam logic [6:0] P_ERR = 7'b0000001;

    typedef struct {
        int         cyc;
        logic [6:0] pulses;
        logic       sel;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic req_mult, req_div, hilo_read, div_by_zero;
    logic aux_a_en, aux_b_en, mult_op, div_op, multdiv_sel;
    logic hilo_we, busy, stall, done, div_zero_exc;
    logic [6:0] pulses;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbQ[$];
    int   base;

    multdiv_sequencer #(
        .MULT_LAT (LAT),
        .DIV_LAT  (LAT),
        .CNT_W    (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_mult     (req_mult),
        .req_div      (req_div),
        .hilo_read    (hilo_read),
        .div_by_zero  (div_by_zero),
        .aux_a_en     (aux_a_en),
        .aux_b_en     (aux_b_en),
        .mult_op      (mult_op),
        .div_op       (div_op),
        .multdiv_sel  (multdiv_sel),
        .hilo_we      (hilo_we),
        .busy         (busy),
        .stall        (stall),
        .done         (done),
        .div_zero_exc (div_zero_exc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign pulses = {aux_a_en, aux_b_en, mult_op, div_op, hilo_we, done, div_zero_exc};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic pushEvent(input int c, input logic [6:0] p, input logic s);
        exp_t e;
        e.cyc    = c;
        e.pulses = p;
        e.sel    = s;
        sbQ.push_back(e);
    endtask

    // Issues a one-cycle request and queues the expected pulse sequence.
    // Returns at the negedge of cycle 1 with the requests already dropped.
    task automatic applyStimulus(input logic m, input logic d, input int endCycle,
                                 input logic [6:0] endPulse, output int b);
        logic sel;
        sel = d && !m;
        @(negedge clk);
        req_mult = m;
        req_div  = d;
        b        = cyc;
        pushEvent(b + 1, P_AUX, sel);
        pushEvent(b + 2, sel ? P_DIV : P_MUL, sel);
        if (endCycle > 0) pushEvent(b + endCycle, endPulse, sel);
        @(negedge clk);
        req_mult = 1'b0;
        req_div  = 1'b0;
    endtask

    // Monitor: any pulse from the DUT must match the head of the scoreboard.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (pulses != 7'b0) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected pulse", 32'(pulses), 32'h0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("event cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("event pulses", 32'(pulses), 32'(e.pulses));
                checkOutput("event sel", 32'(multdiv_sel), 32'(e.sel));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset       = 1'b1;
        req_mult    = 1'b0;
        req_div     = 1'b0;
        hilo_read   = 1'b0;
        div_by_zero = 1'b0;
        #3;
        checkOutput("reset outputs", 32'({pulses, busy, stall, multdiv_sel}), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] multiply, normal completion");
        applyStimulus(1'b1, 1'b0, 3 + LAT, P_WB, base);
        for (int k = 1; k <= 8; k++) begin
            checkOutput("mult busy", 32'(busy), 32'(k <= 7));
            checkOutput("mult sel", 32'(multdiv_sel), 32'h0);
            @(negedge clk);
        end

        $display("[TB] divide, normal completion");
        applyStimulus(1'b0, 1'b1, 3 + LAT, P_WB, base);
        for (int k = 1; k <= 8; k++) begin
            checkOutput("div sel", 32'(multdiv_sel), 32'(k <= 7));
            @(negedge clk);
        end

        $display("[TB] divide by zero");
        applyStimulus(1'b0, 1'b1, 5, P_ERR, base);
        repeat (3) @(negedge clk);
        div_by_zero = 1'b1;
        @(negedge clk);
        div_by_zero = 1'b0;
        checkOutput("err busy c5", 32'(busy), 32'h1);
        @(negedge clk);
        checkOutput("err busy c6", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);

        $display("[TB] simultaneous requests and request while busy");
        applyStimulus(1'b1, 1'b1, 3 + LAT, P_WB, base);
        repeat (3) @(negedge clk);
        req_div = 1'b1;
        #1;
        checkOutput("busy req stall", 32'(stall), 32'h1);
        @(negedge clk);
        req_div = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("no second op", 32'(busy), 32'h0);

        $display("[TB] hilo_read stall window");
        applyStimulus(1'b1, 1'b0, 3 + LAT, P_WB, base);
        hilo_read = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            checkOutput("read stall", 32'(stall), 32'(k <= 6));
            @(negedge clk);
        end
        hilo_read = 1'b0;

        $display("[TB] async reset mid-run");
        applyStimulus(1'b1, 1'b0, 0, 7'b0, base);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset outs", 32'({pulses, busy, stall, multdiv_sel}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post reset idle", 32'(busy), 32'h0);
        applyStimulus(1'b1, 1'b0, 3 + LAT, P_WB, base);
        repeat (8) @(negedge clk);
        checkOutput("post reset done", 32'(busy), 32'h0);

        checkOutput("scoreboard empty", 32'(sbQ.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
